// File: rtl/chess_square.sv
// One square of the systolic move generator: emits rays for its own piece, forwards
// sliding rays when empty, and turns each incoming ray into a registered move candidate.
module chess_square (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        engineColor,
   input  logic [5:0]  pieceReg,
   input  logic        enable,
   input  logic        clear,
   input  logic [5:0]  posReg,
   input  logic [10:0] U_in,
   input  logic [10:0] D_in,
   input  logic [10:0] L_in,
   input  logic [10:0] R_in,
   input  logic [10:0] UL_in,
   input  logic [10:0] UR_in,
   input  logic [10:0] DL_in,
   input  logic [10:0] DR_in,
   input  logic [7:0]  UUL_in,
   input  logic [7:0]  UUR_in,
   input  logic [7:0]  LLU_in,
   input  logic [7:0]  RRU_in,
   input  logic [7:0]  DDL_in,
   input  logic [7:0]  DDR_in,
   input  logic [7:0]  LLD_in,
   input  logic [7:0]  RRD_in,
   output logic [10:0] U_out,
   output logic [10:0] D_out,
   output logic [10:0] L_out,
   output logic [10:0] R_out,
   output logic [10:0] UL_out,
   output logic [10:0] UR_out,
   output logic [10:0] DL_out,
   output logic [10:0] DR_out,
   output logic [7:0]  UUL_out,
   output logic [7:0]  UUR_out,
   output logic [7:0]  LLU_out,
   output logic [7:0]  RRU_out,
   output logic [7:0]  DDL_out,
   output logic [7:0]  DDR_out,
   output logic [7:0]  LLD_out,
   output logic [7:0]  RRD_out,
   output logic [23:0] U_move,
   output logic [23:0] D_move,
   output logic [23:0] L_move,
   output logic [23:0] R_move,
   output logic [23:0] UL_move,
   output logic [23:0] UR_move,
   output logic [23:0] DL_move,
   output logic [23:0] DR_move,
   output logic [23:0] UUL_move,
   output logic [23:0] UUR_move,
   output logic [23:0] LLU_move,
   output logic [23:0] RRU_move,
   output logic [23:0] DDL_move,
   output logic [23:0] DDR_move,
   output logic [23:0] LLD_move,
   output logic [23:0] RRD_move
);

   // Slider index order: U D L R UL UR DL DR; knight order: UUL UUR LLU RRU DDL DDR LLD RRD
   logic [10:0] rays     [8];
   logic [7:0]  knights  [8];
   logic [10:0] ray_nxt  [8];
   logic [10:0] ray_p1   [8];
   logic [7:0]  kn_nxt   [8];
   logic [7:0]  kn_p1    [8];
   logic [23:0] move_nxt [16];
   logic [23:0] move_p1  [16];

   logic        empty, own, opp, orth, fwd, hit, kn_hit;
   logic [4:0]  captured, mover;
   logic [3:0]  own_atk;
   logic [10:0] src;

   assign rays    = '{U_in, D_in, L_in, R_in, UL_in, UR_in, DL_in, DR_in};
   assign knights = '{UUL_in, UUR_in, LLU_in, RRU_in, DDL_in, DDR_in, LLD_in, RRD_in};

   // U<->D, L<->R within the orthogonal half; UL<->DR, UR<->DL within the diagonal half
   function automatic logic [2:0] opposite(input logic [2:0] d);
      return d[2] ? (d ^ 3'd3) : (d ^ 3'd1);
   endfunction

   function automatic logic ray_ok(input logic [10:0] r, input logic is_orth, input logic color);
      return (r[10] == color) && (r[7] || r[6] || (is_orth ? r[9] : r[8]));
   endfunction

   function automatic logic [4:0] mover_of(input logic [3:0] atk);
      if (atk[3] && atk[2]) return 5'b11000;
      else if (atk[3])      return 5'b10000;
      else if (atk[2])      return 5'b01000;
      else if (atk[1])      return 5'b00100;
      else if (atk[0])      return 5'b00010;
      else                  return 5'b00000;
   endfunction

   always_comb begin
      empty    = (pieceReg[4:0] == 5'd0);
      own      = !empty && (pieceReg[5] == engineColor);
      opp      = !empty && !own;
      captured = opp ? pieceReg[4:0] : 5'd0;
      orth     = 1'b0;
      fwd      = 1'b0;
      own_atk  = '0;
      src      = '0;
      mover    = '0;
      hit      = 1'b0;
      kn_hit   = 1'b0;
      for (int d = 0; d < 8; d++) begin
         orth    = (d < 4);
         // Pawn rays point forward: U/UL/UR for white, D/DL/DR for black
         fwd     = engineColor ? (d == 0 || d == 4 || d == 5) : (d == 1 || d == 6 || d == 7);
         own_atk = {orth & pieceReg[4], ~orth & pieceReg[3], pieceReg[2], pieceReg[1] & fwd};
         src     = rays[opposite(3'(d))];
         ray_nxt[d] = '0;
         if (own && own_atk != 4'd0)
            ray_nxt[d] = {engineColor, own_atk, posReg};
         else if (empty && ray_ok(src, orth, engineColor) && (orth ? src[9] : src[8]))
            ray_nxt[d] = {src[10], src[9:8], 2'b00, src[5:0]};

         mover = mover_of(rays[d][9:6]);
         hit   = ray_ok(rays[d], orth, engineColor) && (empty || opp) &&
                 ((mover != 5'b00010) || (orth ? empty : opp));
         move_nxt[d] = hit ? {1'b1, rays[d][5:0], posReg, mover, captured, opp} : '0;

         kn_nxt[d]     = (own && pieceReg[0]) ? {engineColor, 1'b1, posReg} : '0;
         kn_hit        = (knights[d][7] == engineColor) && knights[d][6] && (empty || opp);
         move_nxt[8+d] = kn_hit ? {1'b1, knights[d][5:0], posReg, 5'b00001, captured, opp} : '0;
      end
   end

   // Output register stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ray_p1  <= '{default: '0};
         kn_p1   <= '{default: '0};
         move_p1 <= '{default: '0};
      end else if (clear) begin
         ray_p1  <= '{default: '0};
         kn_p1   <= '{default: '0};
         move_p1 <= '{default: '0};
      end else if (enable) begin
         ray_p1  <= ray_nxt;
         kn_p1   <= kn_nxt;
         move_p1 <= move_nxt;
      end
   end

   assign U_out    = ray_p1[0];
   assign D_out    = ray_p1[1];
   assign L_out    = ray_p1[2];
   assign R_out    = ray_p1[3];
   assign UL_out   = ray_p1[4];
   assign UR_out   = ray_p1[5];
   assign DL_out   = ray_p1[6];
   assign DR_out   = ray_p1[7];
   assign UUL_out  = kn_p1[0];
   assign UUR_out  = kn_p1[1];
   assign LLU_out  = kn_p1[2];
   assign RRU_out  = kn_p1[3];
   assign DDL_out  = kn_p1[4];
   assign DDR_out  = kn_p1[5];
   assign LLD_out  = kn_p1[6];
   assign RRD_out  = kn_p1[7];
   assign U_move   = move_p1[0];
   assign D_move   = move_p1[1];
   assign L_move   = move_p1[2];
   assign R_move   = move_p1[3];
   assign UL_move  = move_p1[4];
   assign UR_move  = move_p1[5];
   assign DL_move  = move_p1[6];
   assign DR_move  = move_p1[7];
   assign UUL_move = move_p1[8];
   assign UUR_move = move_p1[9];
   assign LLU_move = move_p1[10];
   assign RRU_move = move_p1[11];
   assign DDL_move = move_p1[12];
   assign DDR_move = move_p1[13];
   assign LLD_move = move_p1[14];
   assign RRD_move = move_p1[15];

endmodule

// File: tb/tb_chess_square.sv
// Bench for chess_square: directed scenarios plus randomized traffic checked
// against a geometric reference model of one board square.
module tb_chess_square;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        engineColor = 1'b0;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic [5:0]  pieceReg = '0;
   logic [5:0]  posReg = '0;
   logic [10:0] rin  [8];
   logic [7:0]  kin  [8];
   logic [10:0] rout [8];
   logic [7:0]  kout [8];
   logic [23:0] mv   [16];
   logic [10:0] e_ray [8];
   logic [7:0]  e_kn  [8];
   logic [23:0] e_mv  [16];
   logic [10:0] n_ray [8];
   logic [7:0]  n_kn  [8];
   logic [23:0] n_mv  [16];
   int errors = 0;
   int checks = 0;

   // Direction vectors (rank step, file step): U D L R UL UR DL DR
   localparam int DRK [8] = '{1, -1, 0, 0, 1, 1, -1, -1};
   localparam int DFL [8] = '{0, 0, -1, 1, -1, 1, -1, 1};

   always #5 clk = ~clk;

   chess_square dut (
      .clk(clk), .rst_n(rst_n), .engineColor(engineColor), .pieceReg(pieceReg),
      .enable(enable), .clear(clear), .posReg(posReg),
      .U_in(rin[0]), .D_in(rin[1]), .L_in(rin[2]), .R_in(rin[3]),
      .UL_in(rin[4]), .UR_in(rin[5]), .DL_in(rin[6]), .DR_in(rin[7]),
      .UUL_in(kin[0]), .UUR_in(kin[1]), .LLU_in(kin[2]), .RRU_in(kin[3]),
      .DDL_in(kin[4]), .DDR_in(kin[5]), .LLD_in(kin[6]), .RRD_in(kin[7]),
      .U_out(rout[0]), .D_out(rout[1]), .L_out(rout[2]), .R_out(rout[3]),
      .UL_out(rout[4]), .UR_out(rout[5]), .DL_out(rout[6]), .DR_out(rout[7]),
      .UUL_out(kout[0]), .UUR_out(kout[1]), .LLU_out(kout[2]), .RRU_out(kout[3]),
      .DDL_out(kout[4]), .DDR_out(kout[5]), .LLD_out(kout[6]), .RRD_out(kout[7]),
      .U_move(mv[0]), .D_move(mv[1]), .L_move(mv[2]), .R_move(mv[3]),
      .UL_move(mv[4]), .UR_move(mv[5]), .DL_move(mv[6]), .DR_move(mv[7]),
      .UUL_move(mv[8]), .UUR_move(mv[9]), .LLU_move(mv[10]), .RRU_move(mv[11]),
      .DDL_move(mv[12]), .DDR_move(mv[13]), .LLD_move(mv[14]), .RRD_move(mv[15])
   );

   function automatic int opposite(input int d);
      for (int i = 0; i < 8; i++)
         if (DRK[i] == -DRK[d] && DFL[i] == -DFL[d]) return i;
      return 0;
   endfunction

   function automatic bit ray_ok(input logic [10:0] r, input bit is_orth);
      return (r[10] == engineColor) && (r[7] || r[6] || (is_orth ? r[9] : r[8]));
   endfunction

   function automatic logic [4:0] piece_of(input logic [3:0] a);
      if (a[3] && a[2]) return 5'b11000;
      if (a[3]) return 5'b10000;
      if (a[2]) return 5'b01000;
      if (a[1]) return 5'b00100;
      if (a[0]) return 5'b00010;
      return 5'b00000;
   endfunction

   task automatic model();
      bit          is_empty, is_own, is_opp, is_orth, ok;
      logic [4:0]  t, who, cap;
      logic [3:0]  a;
      logic [10:0] r;
      int          pawn_step;
      t         = pieceReg[4:0];
      is_empty  = (t == 5'd0);
      is_own    = !is_empty && (pieceReg[5] == engineColor);
      is_opp    = !is_empty && !is_own;
      cap       = is_opp ? t : 5'd0;
      pawn_step = engineColor ? 1 : -1;
      for (int d = 0; d < 8; d++) begin
         is_orth  = (DRK[d] == 0) || (DFL[d] == 0);
         n_ray[d] = '0;
         if (is_own) begin
            a = '0;
            if (is_orth && t[4]) a[3] = 1'b1;
            if (!is_orth && t[3]) a[2] = 1'b1;
            if (t[2]) a[1] = 1'b1;
            if (t[1] && DRK[d] == pawn_step) a[0] = 1'b1;
            if (a != 4'd0) n_ray[d] = {engineColor, a, posReg};
         end else if (is_empty) begin
            r = rin[opposite(d)];
            if (ray_ok(r, is_orth) && (is_orth ? r[9] : r[8]))
               n_ray[d] = {r[10], r[9:8], 2'b00, r[5:0]};
         end
         r   = rin[d];
         who = piece_of(r[9:6]);
         ok  = ray_ok(r, is_orth) && (is_empty || is_opp);
         if (who == 5'b00010) ok = ok && (is_orth ? is_empty : is_opp);
         n_mv[d] = ok ? {1'b1, r[5:0], posReg, who, cap, is_opp} : 24'd0;
         n_kn[d] = (is_own && t[0]) ? {engineColor, 1'b1, posReg} : 8'd0;
         ok = (kin[d][7] == engineColor) && kin[d][6] && (is_empty || is_opp);
         n_mv[8+d] = ok ? {1'b1, kin[d][5:0], posReg, 5'b00001, cap, is_opp} : 24'd0;
      end
   endtask

   task automatic zero_exp();
      for (int i = 0; i < 8; i++) begin
         e_ray[i] = '0;
         e_kn[i]  = '0;
      end
      for (int i = 0; i < 16; i++) e_mv[i] = '0;
   endtask

   task automatic step();
      model();
      @(posedge clk);
      #1;
      if (clear) zero_exp();
      else if (enable) begin
         e_ray = n_ray;
         e_kn  = n_kn;
         e_mv  = n_mv;
      end
   endtask

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s ray%0d", tag, i), 24'(rout[i]), 24'(e_ray[i]));
         check($sformatf("%s kn%0d", tag, i), 24'(kout[i]), 24'(e_kn[i]));
      end
      for (int i = 0; i < 16; i++)
         check($sformatf("%s move%0d", tag, i), mv[i], e_mv[i]);
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 8; i++) begin
         rin[i] = '0;
         kin[i] = '0;
      end
   endtask

   function automatic logic [10:0] rand_ray();
      logic [3:0] a;
      case ($urandom_range(0, 6))
         0: a = 4'b1000;
         1: a = 4'b0100;
         2: a = 4'b1100;
         3: a = 4'b0010;
         4: a = 4'b0001;
         5: a = 4'($urandom);
         default: a = 4'b0000;
      endcase
      return {($urandom_range(0, 3) == 0) ? ~engineColor : engineColor, a, 6'($urandom)};
   endfunction

   function automatic logic [4:0] rand_type();
      case ($urandom_range(0, 6))
         0: return 5'b10000;
         1: return 5'b01000;
         2: return 5'b11000;
         3: return 5'b00100;
         4: return 5'b00010;
         5: return 5'b00001;
         default: return 5'b00000;
      endcase
   endfunction

   task automatic randomize_inputs();
      engineColor = 1'($urandom);
      pieceReg    = {1'($urandom), rand_type()};
      posReg      = 6'($urandom);
      for (int i = 0; i < 8; i++) begin
         rin[i] = rand_ray();
         kin[i] = {($urandom_range(0, 3) == 0) ? ~engineColor : engineColor, 1'($urandom), 6'($urandom)};
      end
   endtask

   initial begin
      clear_inputs();
      zero_exp();
      #2;
      check_all("reset");
      #10;
      rst_n  = 1'b1;
      enable = 1'b1;

      // Opponent bishop on 28 attacked by black sliders and a knight
      engineColor = 1'b0;
      pieceReg    = {1'b1, 5'b01000};
      posReg      = 6'd28;
      rin[1]      = {1'b0, 4'b1000, 6'd20};
      rin[2]      = {1'b0, 4'b1100, 6'd29};
      rin[6]      = {1'b0, 4'b0100, 6'd21};
      kin[1]      = {1'b0, 1'b1, 6'd43};
      step();
      check("t1 D_move", mv[1], {1'b1, 6'd20, 6'd28, 5'b10000, 5'b01000, 1'b1});
      check("t1 L_move", mv[2], {1'b1, 6'd29, 6'd28, 5'b11000, 5'b01000, 1'b1});
      check("t1 DL_move", mv[6], {1'b1, 6'd21, 6'd28, 5'b01000, 5'b01000, 1'b1});
      check("t1 UUR_move", mv[9], {1'b1, 6'd43, 6'd28, 5'b00001, 5'b01000, 1'b1});
      check_all("t1");

      // Empty square forwards a queen ray
      clear_inputs();
      pieceReg = '0;
      rin[1]   = {1'b0, 4'b1100, 6'd20};
      step();
      check("t2 U_out", 24'(rout[0]), 24'({1'b0, 4'b1100, 6'd20}));
      check("t2 D_move", mv[1], {1'b1, 6'd20, 6'd28, 5'b11000, 5'b00000, 1'b0});
      check_all("t2");

      // Own white rook at 0; a white ray onto it is blocked
      clear_inputs();
      engineColor = 1'b1;
      pieceReg    = {1'b1, 5'b10000};
      posReg      = 6'd0;
      rin[5]      = {1'b1, 4'b0100, 6'd9};
      step();
      check("t3 U_out", 24'(rout[0]), 24'({1'b1, 4'b1000, 6'd0}));
      check("t3 R_out", 24'(rout[3]), 24'({1'b1, 4'b1000, 6'd0}));
      check("t3 UR_out", 24'(rout[5]), 24'd0);
      check("t3 UR_move", mv[5], 24'd0);
      check_all("t3");

      // Own white pawn at 12
      clear_inputs();
      pieceReg = {1'b1, 5'b00010};
      posReg   = 6'd12;
      step();
      check("t4 U_out", 24'(rout[0]), 24'({1'b1, 4'b0001, 6'd12}));
      check("t4 UL_out", 24'(rout[4]), 24'({1'b1, 4'b0001, 6'd12}));
      check("t4 UR_out", 24'(rout[5]), 24'({1'b1, 4'b0001, 6'd12}));
      check("t4 D_out", 24'(rout[1]), 24'd0);
      check_all("t4");

      // Pawn rays into an empty target: push allowed, capture not
      clear_inputs();
      pieceReg = '0;
      posReg   = 6'd20;
      rin[1]   = {1'b1, 4'b0001, 6'd12};
      rin[6]   = {1'b1, 4'b0001, 6'd11};
      step();
      check("t5 D_move", mv[1], {1'b1, 6'd12, 6'd20, 5'b00010, 5'b00000, 1'b0});
      check("t5 DL_move", mv[6], 24'd0);
      check_all("t5");

      // Control: load a busy state, then hold, clear, and async reset
      engineColor = 1'b0;
      pieceReg    = {1'b1, 5'b11000};
      posReg      = 6'd35;
      for (int i = 0; i < 8; i++) begin
         rin[i] = {1'b0, (i < 4) ? 4'b1000 : 4'b0100, 6'(i)};
         kin[i] = {1'b0, 1'b1, 6'(i + 40)};
      end
      step();
      check_all("load");
      randomize_inputs();
      enable = 1'b0;
      step();
      check_all("hold");
      enable = 1'b1;
      clear  = 1'b1;
      step();
      check_all("clear");
      clear       = 1'b0;
      engineColor = 1'b0;
      pieceReg    = '0;
      for (int i = 0; i < 8; i++) begin
         rin[i] = {1'b0, 4'b1100, 6'(i + 8)};
         kin[i] = {1'b0, 1'b1, 6'(i + 16)};
      end
      step();
      check_all("reload");
      #2;
      rst_n = 1'b0;
      #1;
      zero_exp();
      check_all("async_rst");
      #1;
      rst_n = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         randomize_inputs();
         enable = ($urandom_range(0, 7) != 0);
         clear  = ($urandom_range(0, 15) == 0);
         step();
         check_all($sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
